// File: rtl/seg_scan.sv
// Multiplexed scan driver for a common-anode seven-segment display.
// Holds a small BCD register file and scans one digit per slot, with a blanking gap at each digit change.
module seg_scan #(
    parameter int DIV    = 50000,
    parameter int BLANK  = 16,
    parameter int DIGITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] wr_data,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    output logic [7:0] seg,
    output logic [7:0] an,
    output logic [2:0] digit_idx,
    output logic       frame_done
);

    localparam int             CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [2:0]     IDX_MAX = 3'(DIGITS - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [3:0]       regs [8];
    logic             blank;

    function automatic logic [7:0] decode(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    // NOTE: the register file is only eight 4-bit flops, so it is cleared on reset like
    // ordinary state; a RAM-inferred array would normally be left unreset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 4'd0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    generate
        if (BLANK == 0) begin : g_no_blank
            assign blank = 1'b0;
        end else begin : g_blank
            localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK);
            assign blank = (cnt < BLANK_C);
        end
    endgenerate

    // Outputs are forced idle while reset is held, so even the first reset cycle is dark.
    // NOTE: every output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        seg        = 8'hFF;
        an         = 8'hFF;
        digit_idx  = 3'd0;
        frame_done = 1'b0;
        if (!reset) begin
            digit_idx  = idx;
            frame_done = (idx == IDX_MAX) && (cnt == CNT_MAX);
            if (!blank) begin
                an  = ~(8'd1 << idx);
                seg = decode(regs[idx]);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed self-checking bench for seg_scan: an 8-digit and a 4-digit instance share clock, reset and write port.
module tb_seg_scan;

    localparam int DIV   = 8;
    localparam int BLANK = 2;

    localparam logic [7:0] SEG_TBL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF
    };

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_data = 4'd0;
    logic [2:0] wr_addr = 3'd0;

    logic [7:0] seg8, an8, seg4, an4;
    logic [2:0] idx8, idx4;
    logic       fd8, fd4;

    int         n_checks = 0;
    int         n_errors = 0;
    int         t = 0;
    logic [3:0] exp_val [8];
    int         pulses8, pulses4;

    seg_scan #(.DIV(DIV), .BLANK(BLANK), .DIGITS(8)) dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .seg(seg8), .an(an8), .digit_idx(idx8), .frame_done(fd8)
    );

    seg_scan #(.DIV(DIV), .BLANK(BLANK), .DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .seg(seg4), .an(an4), .digit_idx(idx4), .frame_done(fd4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the model tracks time since reset and the written digits.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            t = 0;
            for (int i = 0; i < 8; i++) exp_val[i] = 4'd0;
        end else begin
            t++;
            if (wr_en) exp_val[wr_addr] = wr_data;
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_until(input int i, input int c);
        int guard = 0;
        while (!(((t / DIV) % 8) == i && (t % DIV) == c)) begin
            tick();
            guard++;
            if (guard > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL wait_until idx=%0d cnt=%0d: observed timeout expected reached", i, c);
                break;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        int c, i8, i4;
        c  = t % DIV;
        i8 = (t / DIV) % 8;
        i4 = (t / DIV) % 4;
        if (reset) begin
            check({tag, ".an8"}, an8, 8'hFF);
            check({tag, ".seg8"}, seg8, 8'hFF);
            check({tag, ".idx8"}, {5'd0, idx8}, 8'd0);
            check({tag, ".fd8"}, {7'd0, fd8}, 8'd0);
            check({tag, ".an4"}, an4, 8'hFF);
            check({tag, ".fd4"}, {7'd0, fd4}, 8'd0);
        end else begin
            check($sformatf("%s.t%0d.an8", tag, t), an8, (c < BLANK) ? 8'hFF : ~(8'd1 << i8));
            check($sformatf("%s.t%0d.seg8", tag, t), seg8, (c < BLANK) ? 8'hFF : SEG_TBL[exp_val[i8]]);
            check($sformatf("%s.t%0d.idx8", tag, t), {5'd0, idx8}, 8'(i8));
            check($sformatf("%s.t%0d.fd8", tag, t), {7'd0, fd8}, (i8 == 7 && c == DIV - 1) ? 8'd1 : 8'd0);
            check($sformatf("%s.t%0d.an4", tag, t), an4, (c < BLANK) ? 8'hFF : ~(8'd1 << i4));
            check($sformatf("%s.t%0d.seg4", tag, t), seg4, (c < BLANK) ? 8'hFF : SEG_TBL[exp_val[i4]]);
            check($sformatf("%s.t%0d.idx4", tag, t), {5'd0, idx4}, 8'(i4));
            check($sformatf("%s.t%0d.fd4", tag, t), {7'd0, fd4}, (i4 == 3 && c == DIV - 1) ? 8'd1 : 8'd0);
        end
    endtask

    initial begin
        // 1. reset held three cycles, then the first slot opens after two blank cycles
        reset = 1'b1;
        repeat (3) begin
            tick();
            check_outputs("reset_hold");
        end
        reset = 1'b0;
        #1;
        check("rel_c0.an", an8, 8'hFF);
        check("rel_c0.seg", seg8, 8'hFF);
        tick();
        check("rel_c1.an", an8, 8'hFF);
        tick();
        check("rel_c2.an", an8, 8'hFE);
        check("rel_c2.seg", seg8, 8'hC0);

        // 2. digits 1..8 written to addresses 0..7, one full frame observed
        for (int a = 0; a < 8; a++) wr(3'(a), 4'(a + 1));
        wait_until(0, 0);
        repeat (64) begin
            check_outputs("frame");
            tick();
        end
        wait_until(3, 2);
        check("slot3.an", an8, 8'hF7);
        check("slot3.seg", seg8, 8'h99);
        wait_until(7, 5);
        check("slot7.an", an8, 8'h7F);
        check("slot7.seg", seg8, 8'h80);

        // 3. out-of-range BCD value shows a dash
        wr(3'd5, 4'd12);
        wait_until(5, 2);
        repeat (6) begin
            check("dash.an", an8, 8'hDF);
            check("dash.seg", seg8, 8'hBF);
            tick();
        end

        // 4. free run: one frame_done every 64 cycles (8 digits) and every 32 (4 digits)
        wait_until(0, 0);
        pulses8 = 0;
        pulses4 = 0;
        repeat (200) begin
            check_outputs("freerun");
            if (fd8) pulses8++;
            if (fd4) pulses4++;
            tick();
        end
        check("pulses8", 8'(pulses8), 8'd3);
        check("pulses4", 8'(pulses4), 8'd6);

        // 5. write to the digit on display lands on the next cycle; write with reset is dropped
        wait_until(2, 4);
        check("live_pre.seg", seg8, 8'hB0);
        check("live_pre.an", an8, 8'hFB);
        wr(3'd2, 4'd9);
        check("live_post.seg", seg8, 8'h90);
        check("live_post.an", an8, 8'hFB);
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd3;
        wr_data = 4'd7;
        tick();
        check_outputs("rst_wr");
        reset = 1'b0;
        wr_en = 1'b0;
        wait_until(3, 2);
        check("rst_wr.an", an8, 8'hF7);
        check("rst_wr.seg", seg8, 8'hC0);

        // 6. reset mid-slot restarts the scan and clears every digit
        for (int a = 0; a < 8; a++) wr(3'(a), 4'(a + 1));
        wait_until(4, 5);
        check("mid.an", an8, 8'hEF);
        check("mid.seg", seg8, 8'h92);
        reset = 1'b1;
        tick();
        check("mid_rst.an", an8, 8'hFF);
        check("mid_rst.seg", seg8, 8'hFF);
        check("mid_rst.idx", {5'd0, idx8}, 8'd0);
        reset = 1'b0;
        repeat (64) begin
            check_outputs("cleared");
            if ((t % DIV) >= BLANK) check("cleared.seg", seg8, 8'hC0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
Multiplexed scan driver for an 8-digit, common-anode seven-segment display. It owns an 8 x 4-bit BCD register file that is written through a clk/data/load/address port. It reads the digits back continuously, one at a time, and drives active-low segment and anode lines. A blanking gap at each digit change suppresses ghosting. It also provides a per-frame strobe so upstream logic can update digits between frames.

Parameters:
DIV, 50000, clock cycles per digit slot; legal range is BLANK+1 to 2^20.
BLANK, 16, leading cycles of each slot during which all anodes and segments are off; 0 disables blanking.
DIGITS, 8, number of digits scanned, indices 0..DIGITS-1; legal range 1-8.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
wr_data  input  4  BCD value to store.
wr_en  input  1  load strobe; writes wr_data on the clock edge when high.
wr_addr  input  3  register index to write.
seg  output  8  active-low segments; bit0=a … bit6=g, bit7=dp.
an  output  8  active-low one-hot anode enables; bit n selects digit n.
digit_idx  output  3  index of the digit currently being scanned.
frame_done  output  1  one-cycle pulse on the last cycle of the last slot in a frame.

Behaviour:
- Internal state:
  - regs[0..7], 4 bits each.
  - cnt, the prescaler, counting 0..DIV-1.
  - idx, the scan index, counting 0..DIGITS-1.
- Reset (synchronous; wins over everything else):
  - regs=0, cnt=0, idx=0.
  - seg=8'hFF, an=8'hFF, digit_idx=0, frame_done=0 for every cycle reset is high.
  - A write asserted in the same cycle as reset is dropped.
- Write path:
  - On an edge with wr_en=1, regs[wr_addr] is loaded with wr_data.
  - Values 10-15 are stored unchanged.
  - Addresses >= DIGITS are stored but never displayed.
  - There is no read port; readback happens only through the scan.
- Prescaler:
  - Each cycle, cnt increments.
  - When cnt==DIV-1, cnt returns to 0 and idx advances.
  - idx wraps from DIGITS-1 to 0.
- Outputs are pure combinational decodes of the registered cnt, idx and regs:
  - cnt < BLANK: an=8'hFF, seg=8'hFF.
  - cnt >= BLANK: an = ~(1<<idx), seg = decode(regs[idx]).
  - digit_idx = idx.
  - frame_done = (idx==DIGITS-1) && (cnt==DIV-1).
- Decode table (hex, active-low, dp always off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - 10-15 show a dash, 8'hBF (segment g only).
- Latency:
  - A write to the digit currently displayed changes seg in the cycle after the write edge.
  - an is unaffected by writes.
- Frame period is DIV*DIGITS cycles, with exactly one frame_done pulse per frame.
- Reset mid-slot: on the next cycle all outputs are blanked and the scan restarts at idx 0, cnt 0. No partial slot is finished.
- wr_en held high continuously: the last write each cycle wins, and scanning is never stalled.

Test Plan:
Bench parameters are DIV=8, BLANK=2, DIGITS=8 unless a scenario states otherwise.
1. Reset held 3 cycles -> an=FF, seg=FF, frame_done=0 throughout. After release, cycles 0-1 are blank; cycle 2 gives an=FE, seg=C0.
2. Write 1..8 to addresses 0..7, then observe one frame:
   - slot 3 non-blank cycles: an=F7, seg=99.
   - slot 7: an=7F, seg=80.
   - slots 0-2 and 4-6 follow the decode table.
3. Write 12 to address 5 -> during slot 5, cnt>=2: an=DF, seg=BF.
4. Free-run 200 cycles:
   - frame_done is high exactly once per 64 cycles, at idx=7, cnt=7.
   - The next cycle has idx=0.
   - Repeat with DIGITS=4: the period is 32 cycles and idx never exceeds 3.
5. During slot 2, cnt=4, write 9 to address 2 -> seg goes from the old code to 90 on the next cycle and an stays FB. Also assert a write together with reset -> the register reads 0 on its next slot (seg=C0).
6. Assert reset at idx=4, cnt=5 -> the next cycle has an=FF and idx=0, and after release every digit shows C0.
